// File: rtl/gate_array_pipe.sv
// gate_array_pipe: registered multi-function gate array with valid/ready flow.
//
// NIN operands of WIDTH bits are combined by one of eight gate functions
// (buf, not, and, or, nand, nor, xor, xnor). The result, its complement and
// the op that produced it are presented through a valid/ready output, and
// res_count counts delivered results (wrapping at 16 bits).
//
// Build option: define GATE_ARRAY_PIPE2_EN to insert an operand register
// stage (stage A) ahead of the function/output stage, giving latency 2.
// Without it the function is evaluated straight from in_data/in_op and
// registered into the output stage, giving latency 1.
//
// Handshake semantics (all ports): a transfer happens on a rising clk edge
// where valid && ready. A producer holding valid keeps its payload stable
// until the transfer; ready may depend combinationally on downstream ready
// but never on the same interface's valid. Each stage is a one-entry
// register that accepts new data when empty or when draining in the same
// cycle, so in_ready = !stage_valid || downstream_ready, chained backward.

module gate_array_pipe #(
  parameter int WIDTH = 4,
  parameter int NIN   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_op,
  input  logic [NIN*WIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [WIDTH-1:0]     out_comp,
  output logic [2:0]           out_op,
  output logic [15:0]          res_count
);

  localparam logic [2:0] OP_BUF  = 3'd0;
  localparam logic [2:0] OP_NOT  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;
  localparam logic [2:0] OP_XNOR = 3'd7;

  // Per-bit reduction across all operands. Operand 0 seeds each accumulator,
  // so with NIN=1 the reductions collapse to operand 0 (or its complement).
  function automatic logic [WIDTH-1:0] gate_eval(
    input logic [2:0]           op,
    input logic [NIN*WIDTH-1:0] data
  );
    logic [WIDTH-1:0] op0;
    logic [WIDTH-1:0] and_r;
    logic [WIDTH-1:0] or_r;
    logic [WIDTH-1:0] xor_r;
    logic [WIDTH-1:0] res;
    op0   = data[WIDTH-1:0];
    and_r = op0;
    or_r  = op0;
    xor_r = op0;
    for (int k = 1; k < NIN; k++) begin
      and_r = and_r & data[k*WIDTH +: WIDTH];
      or_r  = or_r  | data[k*WIDTH +: WIDTH];
      xor_r = xor_r ^ data[k*WIDTH +: WIDTH];
    end
    case (op)
      OP_BUF:  res = op0;
      OP_NOT:  res = ~op0;
      OP_AND:  res = and_r;
      OP_OR:   res = or_r;
      OP_NAND: res = ~and_r;
      OP_NOR:  res = ~or_r;
      OP_XOR:  res = xor_r;
      OP_XNOR: res = ~xor_r;
      default: res = op0;
    endcase
    return res;
  endfunction

  // Output stage registers
  logic             o_valid;
  logic [WIDTH-1:0] o_data;
  logic [2:0]       o_op;

  // Output stage control
  logic             o_ready;
  logic             o_load;
  logic             out_xfer;
  logic [WIDTH-1:0] o_data_d;
  logic [2:0]       o_op_d;

  assign out_xfer = o_valid && out_ready;
  assign o_ready  = !o_valid || out_ready;

`ifdef GATE_ARRAY_PIPE2_EN

  // Stage A: raw operands and op, evaluated one cycle later.
  logic                 a_valid;
  logic [NIN*WIDTH-1:0] a_data;
  logic [2:0]           a_op;
  logic                 a_load;

  assign in_ready = !a_valid || o_ready;
  assign a_load   = in_valid && in_ready;
  assign o_load   = a_valid && o_ready;
  assign o_data_d = gate_eval(a_op, a_data);
  assign o_op_d   = a_op;

  // Stage A register: capture operands on input transfer, empty on drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid <= 1'b0;
      a_data  <= '0;
      a_op    <= '0;
    end else if (a_load) begin
      a_valid <= 1'b1;
      a_data  <= in_data;
      a_op    <= in_op;
    end else if (o_load) begin
      a_valid <= 1'b0;
    end
  end

`else

  assign in_ready = o_ready;
  assign o_load   = in_valid && in_ready;
  assign o_data_d = gate_eval(in_op, in_data);
  assign o_op_d   = in_op;

`endif

  // Output stage register: load a new result when empty or draining,
  // otherwise hold the current result stable under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_op    <= '0;
    end else if (o_load) begin
      o_valid <= 1'b1;
      o_data  <= o_data_d;
      o_op    <= o_op_d;
    end else if (out_xfer) begin
      o_valid <= 1'b0;
    end
  end

  // Delivered-result counter: one count per output transfer, wraps at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_count <= '0;
    end else if (out_xfer) begin
      res_count <= res_count + 16'd1;
    end
  end

  assign out_valid = o_valid;
  assign out_data  = o_data;
  assign out_comp  = ~o_data;
  assign out_op    = o_op;

endmodule

// File: tb/tb_gate_array_pipe.sv
// Testbench for gate_array_pipe (WIDTH=4, NIN=4). Works with or without
// GATE_ARRAY_PIPE2_EN defined; only the latency constant changes.

module tb_gate_array_pipe;

  localparam int W = 4;
  localparam int N = 4;
`ifdef GATE_ARRAY_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [2:0]     in_op;
  logic [N*W-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [W-1:0]   out_comp;
  logic [2:0]     out_op;
  logic [15:0]    res_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: {op, expected data} per accepted input, plus expected count.
  logic [3+W-1:0] exp_q[$];
  logic [15:0]    exp_cnt = 16'd0;

  gate_array_pipe #(.WIDTH(W), .NIN(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_comp  (out_comp),
    .out_op    (out_op),
    .res_count (res_count)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  // Counts ones per bit position and decides from the count.
  function automatic logic [W-1:0] model(input logic [2:0] op, input logic [N*W-1:0] d);
    logic [W-1:0] r;
    int ones;
    for (int b = 0; b < W; b++) begin
      ones = 0;
      for (int k = 0; k < N; k++) ones += int'(d[k*W+b]);
      case (op)
        3'd0: r[b] = d[b];
        3'd1: r[b] = ~d[b];
        3'd2: r[b] = (ones == N);
        3'd3: r[b] = (ones != 0);
        3'd4: r[b] = (ones != N);
        3'd5: r[b] = (ones == 0);
        3'd6: r[b] = (ones % 2 == 1);
        default: r[b] = (ones % 2 == 0);
      endcase
    end
    return r;
  endfunction

  // ---------------- scoreboard monitor ----------------
  // Sampled mid-cycle: check res_count and any output transfer, then record
  // any input transfer that the coming edge will perform.
  always @(negedge clk) begin
    logic [3+W-1:0] e;
    if (rst === 1'b1) begin
      exp_q.delete();
      exp_cnt = 16'd0;
    end else begin
      n_checks++;
      if (res_count !== exp_cnt) begin
        n_fail++;
        $display("FAIL res_count: got %h, need %h", res_count, exp_cnt);
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got data %h op %0d, need no output", out_data, out_op);
        end else begin
          e = exp_q.pop_front();
          n_checks++;
          if (out_data !== e[W-1:0]) begin
            n_fail++;
            $display("FAIL sb_data: got %h, need %h (op %0d)", out_data, e[W-1:0], e[3+W-1:W]);
          end
          n_checks++;
          if (out_comp !== ~e[W-1:0]) begin
            n_fail++;
            $display("FAIL sb_comp: got %h, need %h", out_comp, ~e[W-1:0]);
          end
          n_checks++;
          if (out_op !== e[3+W-1:W]) begin
            n_fail++;
            $display("FAIL sb_op: got %0d, need %0d", out_op, e[3+W-1:W]);
          end
        end
        exp_cnt = exp_cnt + 16'd1;
      end
      if (in_valid === 1'b1 && in_ready === 1'b1)
        exp_q.push_back({in_op, model(in_op, in_data)});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Present one transfer and hold it until accepted (bounded).
  task automatic drive(input logic [2:0] op, input logic [N*W-1:0] d);
    logic acc;
    in_op = op;
    in_data = d;
    in_valid = 1'b1;
    acc = 1'b0;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
    end
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL drive_timeout: got in_ready 0 for 200 cycles, need 1");
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_op = 3'd0;
    in_data = '0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_valid: got %b, need 0", out_valid); end
    n_checks++; if (out_data !== 4'h0)   begin n_fail++; $display("FAIL reset_data: got %h, need 0", out_data); end
    n_checks++; if (out_comp !== 4'hF)   begin n_fail++; $display("FAIL reset_comp: got %h, need f", out_comp); end
    n_checks++; if (out_op !== 3'd0)     begin n_fail++; $display("FAIL reset_op: got %0d, need 0", out_op); end
    n_checks++; if (res_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %h, need 0", res_count); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_and();
    do_reset();
    out_ready = 1'b1;
    drive(3'd2, {4'h7, 4'hF, 4'hF, 4'hF});
    idle();
    repeat (LAT - 1) begin @(posedge clk); #1; end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL and_valid: got %b, need 1", out_valid); end
    n_checks++; if (out_data !== 4'h7)  begin n_fail++; $display("FAIL and_data: got %h, need 7", out_data); end
    n_checks++; if (out_comp !== 4'h8)  begin n_fail++; $display("FAIL and_comp: got %h, need 8", out_comp); end
    n_checks++; if (out_op !== 3'd2)    begin n_fail++; $display("FAIL and_op: got %0d, need 2", out_op); end
    @(negedge clk);
    n_checks++; if (res_count !== 16'd1) begin n_fail++; $display("FAIL and_count: got %h, need 1", res_count); end
  endtask

  task automatic test_xor_back_to_back();
    logic         v[12];
    logic [W-1:0] dc[12];
    logic [2:0]   oc[12];
    int first;
    do_reset();
    out_ready = 1'b1;
    fork
      begin
        drive(3'd6, {4'h8, 4'h4, 4'h2, 4'h1});
        drive(3'd7, {4'h8, 4'h4, 4'h2, 4'h1});
        idle();
      end
      begin
        for (int i = 0; i < 12; i++) begin
          @(negedge clk);
          v[i] = out_valid; dc[i] = out_data; oc[i] = out_op;
        end
      end
    join
    first = -1;
    for (int i = 11; i >= 0; i--) if (v[i] === 1'b1) first = i;
    n_checks++;
    if (first < 0 || first > 10) begin
      n_fail++;
      $display("FAIL b2b_present: got first valid index %0d, need 0..10", first);
    end else begin
      n_checks++; if (dc[first] !== 4'hF || oc[first] !== 3'd6)
        begin n_fail++; $display("FAIL xor_data: got %h op %0d, need f op 6", dc[first], oc[first]); end
      n_checks++; if (v[first+1] !== 1'b1)
        begin n_fail++; $display("FAIL b2b_gap: got valid %b after first result, need 1", v[first+1]); end
      n_checks++; if (dc[first+1] !== 4'h0 || oc[first+1] !== 3'd7)
        begin n_fail++; $display("FAIL xnor_data: got %h op %0d, need 0 op 7", dc[first+1], oc[first+1]); end
    end
  endtask

  task automatic test_buf_not();
    logic [W-1:0] got[4];
    logic [W-1:0] want[4];
    int n;
    want[0] = 4'hA; want[1] = 4'h5; want[2] = 4'hA; want[3] = 4'h5;
    do_reset();
    out_ready = 1'b1;
    n = 0;
    fork
      begin
        drive(3'd0, {4'hF, 4'hF, 4'hF, 4'hA});
        drive(3'd1, {4'hF, 4'hF, 4'hF, 4'hA});
        drive(3'd0, {4'h0, 4'h3, 4'hC, 4'hA});
        drive(3'd1, {4'h0, 4'h0, 4'h0, 4'hA});
        idle();
      end
      begin
        for (int i = 0; i < 16 && n < 4; i++) begin
          @(negedge clk);
          if (out_valid === 1'b1) begin got[n] = out_data; n++; end
        end
      end
    join
    n_checks++;
    if (n != 4) begin
      n_fail++;
      $display("FAIL bufnot_count: got %0d results, need 4", n);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (got[i] !== want[i]) begin
          n_fail++;
          $display("FAIL bufnot_%0d: got %h, need %h", i, got[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held;
    do_reset();
    out_ready = 1'b0;
    fork
      begin
        drive(3'd2, {4'h3, 4'hF, 4'hF, 4'hF});
        drive(3'd2, {4'hF, 4'hC, 4'hF, 4'hF});
        idle();
      end
      begin
        repeat (4) @(negedge clk);
        n_checks++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL bp_in_ready: got %b, need 0", in_ready); end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b, need 1", out_valid); end
        n_checks++; if (out_data !== 4'h3 || out_op !== 3'd2)
          begin n_fail++; $display("FAIL bp_first: got %h op %0d, need 3 op 2", out_data, out_op); end
        held = out_data;
        @(negedge clk);
        n_checks++; if (out_data !== held || out_valid !== 1'b1)
          begin n_fail++; $display("FAIL bp_hold: got %h valid %b, need %h valid 1", out_data, out_valid, held); end
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        out_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (res_count !== 16'd2) begin n_fail++; $display("FAIL bp_count: got %h, need 2", res_count); end
        n_checks++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL bp_drained: got valid %b, need 0", out_valid); end
        n_checks++; if (exp_q.size() != 0)   begin n_fail++; $display("FAIL bp_pending: got %0d outstanding, need 0", exp_q.size()); end
      end
    join
  endtask

  task automatic test_random();
    logic done;
    done = 1'b0;
    do_reset();
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            idle();
            @(posedge clk); #1;
          end
          drive(3'($urandom_range(0, 7)), 16'($urandom_range(0, 65535)));
        end
        idle();
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b1;
    repeat (LAT + 2) begin @(posedge clk); #1; end
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL random_drain: got %0d outstanding valid %b, need 0 and 0", exp_q.size(), out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int t;
    do_reset();
    out_ready = 1'b0;
    drive(3'd3, {4'h8, 4'h4, 4'h2, 4'h1});
    in_op = 3'd6;
    in_data = {4'h1, 4'h1, 4'h1, 4'h1};
    t = 0;
    while (out_valid !== 1'b1 && t < 10) begin @(negedge clk); t++; end
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_fill: got valid %b, need 1", out_valid); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL mid_valid: got %b, need 0", out_valid); end
    n_checks++; if (out_data !== 4'h0)   begin n_fail++; $display("FAIL mid_data: got %h, need 0", out_data); end
    n_checks++; if (out_comp !== 4'hF)   begin n_fail++; $display("FAIL mid_comp: got %h, need f", out_comp); end
    n_checks++; if (res_count !== 16'd0) begin n_fail++; $display("FAIL mid_count: got %h, need 0", res_count); end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_stale: got valid 1 data %h at cycle %0d, need 0", out_data, i);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 65536; i++)
      drive(3'($urandom_range(0, 7)), 16'($urandom_range(0, 65535)));
    idle();
    repeat (LAT + 2) begin @(posedge clk); #1; end
    @(negedge clk);
    n_checks++; if (res_count !== 16'd0) begin n_fail++; $display("FAIL wrap_count: got %h, need 0", res_count); end
    n_checks++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL wrap_drain: got valid %b, need 0", out_valid); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_and();
    test_xor_back_to_back();
    test_buf_not();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_array_pipe.md
# gate_array_pipe

Parametrised, registered multi-function gate array: combines NIN operands of WIDTH bits with one of eight selectable gate functions (buf, not, and, or, nand, nor, xor, xnor) and returns the result and its complement through a valid/ready pipeline. It is the sequential, multi-bit successor to our single-bit gate-primitive test modules. It sits between a stimulus source and a checker in the gate-level regression designs, and adds flow control and a delivered-result counter.

## Interface
- WIDTH, 4, bit width of each operand and of the result
- NIN, 4, number of operands; legal range 1..8
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands and op are valid
- in_ready  output  1  block accepts a transfer this cycle
- in_op  input  3  function select, encoded below
- in_data  input  NIN*WIDTH  operand k at bits [k*WIDTH +: WIDTH]
- out_valid  output  1  result is valid
- out_ready  input  1  consumer accepts the result
- out_data  output  WIDTH  result
- out_comp  output  WIDTH  bitwise complement of out_data
- out_op  output  3  op that produced out_data
- res_count  output  16  number of completed output handshakes

## Operation
- Op encoding:
  - 0 BUF: operand 0
  - 1 NOT: ~operand 0
  - 2 AND, 3 OR, 4 NAND, 5 NOR, 6 XOR, 7 XNOR: bitwise reduction across all NIN operands, per bit position
- BUF and NOT ignore operands 1..NIN-1.
- With NIN=1, AND/OR/XOR return operand 0, and NAND/NOR/XNOR return its complement.
- Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- Each pipeline stage is a one-entry register with its own valid bit. A stage loads when it is empty or when it drains in the same cycle.
- in_ready = !stage_valid || out_ready for the last stage; this propagates backward stage by stage. in_ready is combinational from out_ready.
- While out_valid && !out_ready, out_data, out_comp and out_op are held stable.
- res_count increments by 1 on every output transfer. It wraps from 16'hFFFF to 16'h0000.
- Simultaneous input and output transfer on a full stage: the new data replaces the old, out_valid stays 1, and res_count increments.
- A no-op cycle (in_valid=0, stage empty) leaves all state unchanged.

## Timing
- Reset values (set at the first rising clk edge with rst=1):
  - out_valid=0
  - out_data=0
  - out_comp=all ones
  - out_op=0
  - res_count=0
  - all internal stage valids=0
- Reset mid-operation discards in-flight results. Discarded results are not counted.
- Latency from input transfer to out_valid high: 1 cycle (default); 2 cycles with GATE_ARRAY_PIPE2_EN.
- Throughput: one transfer per cycle when out_ready is held at 1.
- in_ready may be 1 during reset; transfers in a reset cycle are discarded.

## Configuration
- GATE_ARRAY_PIPE2_EN undefined:
  - single stage
  - gate function computed combinationally from in_data/in_op
  - result registered into the output stage
  - latency 1
- GATE_ARRAY_PIPE2_EN defined:
  - stage A registers in_data and in_op
  - stage B computes the function from stage A and registers the result
  - latency 2
  - in_ready is derived through both stages' occupancy
  - functional results, ordering and res_count are identical to the undefined case

## Test plan
- WIDTH=4, NIN=4, op=2 (AND), operands F,F,F,7, out_ready=1 -> one cycle later (two with the macro): out_data=4'h7, out_comp=4'h8, out_op=2, res_count=1.
- op=6 (XOR), operands 1,2,4,8 -> out_data=4'hF; op=7 (XNOR) with the same operands -> out_data=4'h0. Back-to-back inputs must give back-to-back outputs.
- op=0 (BUF), operands A,F,F,F -> 4'hA; op=1 (NOT), same operands -> 4'h5. Operands 1..3 must have no effect.
- Backpressure: out_ready=0, two AND inputs offered -> first result held stable, in_ready=0 once all stages are full. Then out_ready=1 for two cycles -> both results delivered in order, res_count=2.
- Wrap: 65536 output handshakes -> res_count returns to 0.
- Reset mid-operation: rst=1 for one cycle while out_valid=1 -> next cycle out_valid=0, out_data=0, out_comp=4'hF, res_count=0, and no stale result is emitted afterwards.
